cvp14_mem_responder: RTL

//  Memory-side responder for the CVP14 core bus (Addr/RD/WR/V/data). Serves core word

---
 rtl/cvp14_mem_pkg.sv | 22 ++
 rtl/cvp14_mem_responder_if.sv | 40 ++++
 rtl/cvp14_sram.sv | 40 ++++
 rtl/cvp14_mem_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cvp14_mem_pkg.sv
// Purpose: shared types, widths and helpers for the CVP14 memory responder.
// Contents: word/address/counter widths, FSM state enum, default error read data,
//           saturating increment helper.
package cvp14_mem_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 16;

    localparam logic [WORD_W-1:0] ERR_DATA_DEF = '0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cvp14_mem_responder_if.sv
// Purpose: bundle of core bus, host preload and status signals of the responder.
// Ports (slave view):
//   in : Addr, RD, WR, V, CpuData      core bus
//   in : LdValid, LdAddr, LdData       host preload request
//   out: RdData                        registered read data to core
//   out: LdReady                       host write accepted (combinational from strobes)
//   out: Ready, AddrErr, ErrAddr, OvfSticky, RdCount, WrCount   status
interface cvp14_mem_responder_if;
    import cvp14_mem_pkg::*;

    logic [ADDR_W-1:0] Addr;
    logic              RD;
    logic              WR;
    logic              V;
    logic [WORD_W-1:0] CpuData;
    logic [WORD_W-1:0] RdData;

    logic              LdValid;
    logic [ADDR_W-1:0] LdAddr;
    logic [WORD_W-1:0] LdData;
    logic              LdReady;

    logic              Ready;
    logic              AddrErr;
    logic [ADDR_W-1:0] ErrAddr;
    logic              OvfSticky;
    logic [CNT_W-1:0]  RdCount;
    logic [CNT_W-1:0]  WrCount;

    modport master (
        output Addr, RD, WR, V, CpuData, LdValid, LdAddr, LdData,
        input  RdData, LdReady, Ready, AddrErr, ErrAddr, OvfSticky, RdCount, WrCount
    );

    modport slave (
        input  Addr, RD, WR, V, CpuData, LdValid, LdAddr, LdData,
        output RdData, LdReady, Ready, AddrErr, ErrAddr, OvfSticky, RdCount, WrCount
    );

endinterface

// File: rtl/cvp14_sram.sv
// Purpose: single-port synchronous word array with registered, enable-gated read.
// Ports:
//   clk, rst        clock; synchronous active-high reset of the read register only
//   we/waddr/wdata  write port (commits on posedge)
//   re/raddr        read request; rdata updates only when re, otherwise holds
//   rdata           registered read data, write-first on same-address collision
module cvp14_sram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10,
    parameter int unsigned W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Storage: no reset, contents survive Reset unless swept by the owner.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register: a same-cycle write to the read address wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/cvp14_mem_responder.sv
// Purpose: memory-side responder for the CVP14 core bus. Serves core word reads
//          (1-cycle latency) and writes from an internal array, accepts host preloads
//          when the core is idle, optionally sweeps the array after Reset, and keeps
//          sticky error/overflow status plus saturating access counters.
// Ports:
//   Clk1   clock, all state on posedge
//   Reset  synchronous, active-high reset
//   bus    cvp14_mem_responder_if.slave: core bus, host preload, status outputs
module cvp14_mem_responder
    import cvp14_mem_pkg::*;
#(
    parameter int unsigned       DEPTH          = 1024,
    parameter bit                CLEAR_ON_RESET = 1'b0,
    parameter logic [WORD_W-1:0] INIT_VAL       = '0,
    parameter logic [WORD_W-1:0] ERR_DATA       = ERR_DATA_DEF
) (
    input  logic                  Clk1,
    input  logic                  Reset,
    cvp14_mem_responder_if.slave  bus
);

    localparam int unsigned     AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]   PTR_END = AW'(DEPTH - 1);
    // One extra bit so DEPTH=65536 still compares correctly against 16-bit addresses.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    state_e            state;
    state_e            state_nxt;
    logic [AW-1:0]     ptr;
    logic              clear_act;
    logic              run_act;

    logic              addr_ok;
    logic              ld_addr_ok;
    logic              core_rd;
    logic              core_wr;
    logic              host_wr;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_re;
    logic [WORD_W-1:0] mem_rdata;

    logic              err_sel;
    logic              addr_err;
    logic [ADDR_W-1:0] err_addr;
    logic              ovf;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;

    // FSM state register.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: sweep ends once the last word is being written.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (ptr == PTR_END) state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        clear_act = 1'b0;
        run_act   = 1'b0;
        case (state)
            ST_CLEAR: clear_act = 1'b1;
            ST_RUN:   run_act   = 1'b1;
            default:  run_act   = 1'b0;
        endcase
    end

    // Clear sweep pointer.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            ptr <= '0;
        end else if (clear_act) begin
            ptr <= ptr + AW'(1);
        end
    end

    assign addr_ok    = {1'b0, bus.Addr}   < DEPTH_X;
    assign ld_addr_ok = {1'b0, bus.LdAddr} < DEPTH_X;
    assign core_rd    = run_act & bus.RD;
    assign core_wr    = run_act & bus.WR;

    // Core strobes always take priority over the host port.
    assign bus.LdReady = run_act & ~bus.RD & ~bus.WR;
    assign host_wr     = bus.LdValid & bus.LdReady & ld_addr_ok;

    // Write port arbitration: clear sweep, then core, then host.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ptr;
        mem_wdata = INIT_VAL;
        if (clear_act) begin
            mem_we = 1'b1;
        end else if (core_wr && addr_ok) begin
            mem_we    = 1'b1;
            mem_waddr = bus.Addr[AW-1:0];
            mem_wdata = bus.CpuData;
        end else if (host_wr) begin
            mem_we    = 1'b1;
            mem_waddr = bus.LdAddr[AW-1:0];
            mem_wdata = bus.LdData;
        end
    end

    assign mem_re = core_rd & addr_ok;

    cvp14_sram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (WORD_W)
    ) u_sram (
        .clk   (Clk1),
        .rst   (Reset),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (bus.Addr[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Status, counters and the out-of-range read selector.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            err_sel  <= 1'b0;
            addr_err <= 1'b0;
            err_addr <= '0;
            ovf      <= 1'b0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
        end else begin
            if (core_rd) begin
                err_sel <= ~addr_ok;
                rd_cnt  <= sat_inc(rd_cnt);
            end
            if (core_wr) begin
                wr_cnt <= sat_inc(wr_cnt);
            end
            if ((core_rd || core_wr) && !addr_ok) begin
                addr_err <= 1'b1;
                if (!addr_err) begin
                    err_addr <= bus.Addr;
                end
            end
            if (run_act && bus.V) begin
                ovf <= 1'b1;
            end
        end
    end

    // Both mux inputs are registers, so RdData changes only at clock edges.
    assign bus.RdData    = err_sel ? ERR_DATA : mem_rdata;
    assign bus.Ready     = run_act;
    assign bus.AddrErr   = addr_err;
    assign bus.ErrAddr   = err_addr;
    assign bus.OvfSticky = ovf;
    assign bus.RdCount   = rd_cnt;
    assign bus.WrCount   = wr_cnt;

endmodule
